// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MAR/MDR memory-access sequencer for the SLC-3 core family. Loads MAR/MDR
//   from the CPU bus, runs each memory read or write for a configurable
//   number of wait cycles, and reports completion with a start/done
//   handshake.
//
//   Optional feature macro: MEM_ACCESS_MMIO_EN
//     defined   : MAR == all-ones is an I/O address. A read captures sw_i into
//                 MDR and a write loads MDR into hex_o. Either one completes in
//                 one cycle and never touches the memory enables.
//     undefined : the all-ones address is ordinary memory, sw_i is unused and
//                 hex_o is tied to 0.
//
// Ports
//   clk, reset           clock (rising edge), async active-low reset
//   bus_i, ld_mar/ld_mdr CPU bus value and MAR/MDR load strobes
//   start_rd/start_wr    access requests (write wins when both are high)
//   busy, done           busy during wait states, one-cycle done pulse
//   mar_q, mdr_q         register contents
//   mem_addr/mem_wdata   memory address/write data (mirror MAR/MDR)
//   mem_rdata            memory read data
//   mem_mem_ena/wr_ena   memory enable / write enable
//   sw_i, hex_o          MMIO switch input / hex display register
module mem_access_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_i,
  input  logic                  ld_mar,
  input  logic                  ld_mdr,
  input  logic                  start_rd,
  input  logic                  start_wr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mar_q,
  output logic [DATA_WIDTH-1:0] mdr_q,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_mem_ena,
  output logic                  mem_wr_ena,
  input  logic [DATA_WIDTH-1:0] sw_i,
  output logic [DATA_WIDTH-1:0] hex_o
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd
      $error("mem_access_unit: RD_LATENCY must be in 1..15");
    end
    if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_wr
      $error("mem_access_unit: WR_LATENCY must be in 1..15");
    end
    if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_aw
      $error("mem_access_unit: ADDR_WIDTH must not exceed DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mar_d;
  logic [DATA_WIDTH-1:0] mdr_d;
  logic [DATA_WIDTH-1:0] hex_q, hex_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ena_q, ena_d;
  logic                  we_q, we_d;
  logic                  io_hit;

`ifdef MEM_ACCESS_MMIO_EN
  assign io_hit = &mar_q;
`else
  logic unused_sw;
  assign io_hit    = 1'b0;
  assign unused_sw = ^sw_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // A start takes priority over same-cycle loads, so the access runs
        // on the MAR/MDR values already held.
        if (start_wr) begin
          if (io_hit) begin
            hex_d   = mdr_q;
            state_d = DONE;
          end else begin
            state_d = WR_WAIT;
            cnt_d   = CW'(WR_LATENCY);
          end
        end else if (start_rd) begin
          if (io_hit) begin
            mdr_d   = sw_i;
            state_d = DONE;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CW'(RD_LATENCY);
          end
        end else begin
          if (ld_mar) mar_d = bus_i[ADDR_WIDTH-1:0];
          if (ld_mdr) mdr_d = bus_i;
        end
      end
      RD_WAIT: begin
        if (cnt_q == CW'(1)) begin
          mdr_d   = mem_rdata;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifndef MEM_ACCESS_MMIO_EN
    hex_d = '0;
`endif
    // Outputs are decoded from the next state so they are registered
    // alongside it and line up with the state cycle by cycle.
    busy_d = (state_d == RD_WAIT) || (state_d == WR_WAIT);
    done_d = (state_d == DONE);
    ena_d  = busy_d;
    we_d   = (state_d == WR_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      hex_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ena_q   <= ena_d;
      we_q    <= we_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_mem_ena = ena_q;
  assign mem_wr_ena  = we_q;
  assign mem_addr    = mar_q;
  assign mem_wdata   = mdr_q;
  assign hex_o       = hex_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit (RD_LATENCY=2, WR_LATENCY=3).
// The reference model tracks MAR/MDR/hex and a memory image as plain
// variables and derives expected latencies and enable counts from the
// access rules.
module tb_mem_access_unit;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int RDL = 2;
  localparam int WRL = 3;
`ifdef MEM_ACCESS_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] bus_i;
  logic          ld_mar, ld_mdr, start_rd, start_wr;
  logic          busy, done;
  logic [AW-1:0] mar_q, mem_addr;
  logic [DW-1:0] mdr_q, mem_wdata, mem_rdata, sw_i, hex_o;
  logic          mem_mem_ena, mem_wr_ena;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .RD_LATENCY(RDL), .WR_LATENCY(WRL)) dut (
    .clk(clk), .reset(reset), .bus_i(bus_i), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .start_rd(start_rd), .start_wr(start_wr), .busy(busy), .done(done),
    .mar_q(mar_q), .mdr_q(mdr_q), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
    .sw_i(sw_i), .hex_o(hex_o));

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ext_mem [256];  // external memory seen by the DUT
  logic [DW-1:0] ref_mem [256];  // model's view of what memory must hold
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr, m_hex;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start_rd = 0; start_wr = 0; ld_mar = 0; ld_mdr = 0;
  endtask

  task automatic idle_chk();
    clr();
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ena", {mem_mem_ena, mem_wr_ena}, 0);
  endtask

  task automatic load(input logic [DW-1:0] v, input bit lm, input bit ld);
    bus_i = v; ld_mar = lm; ld_mdr = ld;
    tick();
    clr();
    if (lm) m_mar = v;
    if (ld) m_mdr = v;
    chk("ld_mar", mar_q, m_mar);
    chk("ld_mdr", mdr_q, m_mdr);
  endtask

  // Issues one access in the current (IDLE or DONE) cycle and returns in the
  // cycle where done is observed, so a following call chains back-to-back.
  task automatic access(input bit wr, input bit rd, input bit noise);
    bit            io;
    int            lat, exp_ena, exp_we, ena_n, we_n, cyc;
    bit            bad, got;
    logic [DW-1:0] exp_mdr, exp_hex, swv;
    io      = MMIO && (m_mar == {AW{1'b1}});
    lat     = io ? 1 : (wr ? WRL + 1 : RDL + 1);
    exp_ena = io ? 0 : (wr ? WRL : RDL);
    exp_we  = (wr && !io) ? WRL : 0;
    swv     = 16'($urandom);
    sw_i    = swv;
    exp_mdr = m_mdr;
    exp_hex = m_hex;
    if (wr) begin
      if (io) exp_hex = m_mdr;
      else    ref_mem[m_mar[7:0]] = m_mdr;
    end else begin
      exp_mdr = io ? swv : ref_mem[m_mar[7:0]];
    end
    start_wr = wr; start_rd = rd;
    if (noise) begin
      ld_mar = 1; ld_mdr = 1; bus_i = 16'($urandom);
    end
    mem_rdata = 16'($urandom);
    ena_n = 0; we_n = 0; bad = 0; got = 0; cyc = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      tick();
      clr();
      if (mem_mem_ena) begin
        ena_n++;
        if (mem_addr !== m_mar) bad = 1;
      end
      if (mem_wr_ena) begin
        we_n++;
        if (mem_wdata !== m_mdr) bad = 1;
        ext_mem[mem_addr[7:0]] = mem_wdata;
      end
      // Read data is only valid in the last enabled read cycle.
      mem_rdata = (mem_mem_ena && !mem_wr_ena && ena_n == RDL) ?
                  ext_mem[mem_addr[7:0]] : 16'($urandom);
      if (done) begin
        got = 1; cyc = k;
        chk("done_busy", busy, 0);
      end else if (busy) begin
        start_rd = 1'($urandom); start_wr = 1'($urandom);
        ld_mar = 1'($urandom); ld_mdr = 1'($urandom); bus_i = 16'($urandom);
      end
    end
    m_mdr = exp_mdr;
    m_hex = exp_hex;
    chk("latency", cyc, lat);
    chk("ena_cycles", ena_n, exp_ena);
    chk("we_cycles", we_n, exp_we);
    chk("addr_wdata_stable", bad, 0);
    chk("mdr", mdr_q, m_mdr);
    chk("mar", mar_q, m_mar);
    chk("hex", hex_o, m_hex);
  endtask

  initial begin
    reset = 0; bus_i = 0; sw_i = 0; mem_rdata = 0; clr();
    for (int i = 0; i < 256; i++) begin
      ext_mem[i] = 16'($urandom);
      ref_mem[i] = ext_mem[i];
    end
    m_mar = 0; m_mdr = 0; m_hex = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ena", {mem_mem_ena, mem_wr_ena}, 0);
    chk("rst_mar", mar_q, 0);
    chk("rst_mdr", mdr_q, 0);
    chk("rst_hex", hex_o, 0);
    reset = 1;
    tick();

    // Read 0x3000 -> 0xBEEF
    ext_mem[8'h00] = 16'hBEEF; ref_mem[8'h00] = 16'hBEEF;
    load(16'h3000, 1, 0);
    access(0, 1, 0);
    chk("read_beef", mdr_q, 16'hBEEF);
    idle_chk();

    // Write 0x1234 to 0x0040
    load(16'h0040, 1, 0);
    load(16'h1234, 0, 1);
    access(1, 0, 0);
    chk("wr_mem", ext_mem[8'h40], 16'h1234);
    idle_chk();

    // Contention: write wins, same-cycle and busy-time loads ignored
    load(16'h0077, 1, 0);
    load(16'hCAFE, 0, 1);
    access(1, 1, 1);
    chk("cont_mem", ext_mem[8'h77], 16'hCAFE);
    idle_chk();

    // Back-to-back reads, second started in the DONE cycle
    load(16'h0040, 1, 0);
    access(0, 1, 0);
    access(0, 1, 0);
    idle_chk();

    // All-ones address: MMIO when enabled, plain memory otherwise
    load(16'hFFFF, 1, 0);
    load(16'h0F0F, 0, 1);
    access(1, 0, 0);
    chk("mmio_hex", hex_o, MMIO ? 16'h0F0F : 16'h0000);
    access(0, 1, 0);
    idle_chk();

    // Reset in the second read wait cycle
    load(16'h0040, 1, 0);
    start_rd = 1;
    tick();
    clr();
    tick();
    reset = 0;
    #1;
    chk("rstmid_ena", {mem_mem_ena, mem_wr_ena}, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_mdr", mdr_q, 0);
    chk("rstmid_mar", mar_q, 0);
    chk("rstmid_hex", hex_o, 0);
    m_mar = 0; m_mdr = 0; m_hex = 0;
    #2 reset = 1;
    idle_chk();
    chk("rstmid_done2", done, 0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 4));
      case (op)
        0: load(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), 1, 0);
        1: load(16'($urandom), 0, 1);
        2: access(0, 1, 1'($urandom));
        3: access(1, 1'($urandom), 1'($urandom));
        default: idle_chk();
      endcase
    end
    idle_chk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
